// File: rtl/mips_register_file_pkg.sv
// Shared constants, types and address helpers for the MIPS register file,
// the decode stage and writeback.
package mips_register_file_pkg;

    localparam int REGADDR_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGS      = 32;

    typedef logic [DATA_WIDTH-1:0]    word_t;
    typedef logic [REGADDR_WIDTH-1:0] regaddr_t;

    localparam regaddr_t REG_ZERO = 5'd0;

    // Register 0 is the hardwired zero, so addressing it is the "no write" encoding.
    function automatic logic is_write(input regaddr_t addr);
        return (addr != REG_ZERO);
    endfunction

    function automatic logic bypass_hit(input regaddr_t rd_addr, input regaddr_t wr_addr);
        return is_write(wr_addr) && (rd_addr == wr_addr);
    endfunction

endpackage

// File: rtl/mips_register_file_if.sv
// Decode/writeback-facing bus of the register file: two read ports, one
// write port and the debug mirror.
interface mips_register_file_if;
    import mips_register_file_pkg::*;

    regaddr_t read1_addr;
    regaddr_t read2_addr;
    regaddr_t write_addr;
    word_t    data_in;
    word_t    data_out1;
    word_t    data_out2;
    word_t    debug_out;

    modport master (
        output read1_addr,
        output read2_addr,
        output write_addr,
        output data_in,
        input  data_out1,
        input  data_out2,
        input  debug_out
    );

    modport slave (
        input  read1_addr,
        input  read2_addr,
        input  write_addr,
        input  data_in,
        output data_out1,
        output data_out2,
        output debug_out
    );

endinterface

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module mips_register_file
    import mips_register_file_pkg::*;
#(
    parameter int DEBUG_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_register_file_if.slave  bus
);

    localparam regaddr_t DEBUG_IDX = regaddr_t'(DEBUG_REG);

    // Register 0 is never stored; only 1..31 exist as flops.
    word_t regs_r [1:NUM_REGS-1];
    word_t view_s [0:NUM_REGS-1];
    word_t rd1_s;
    word_t rd2_s;
    word_t dbg_s;

    // Writeback port: async clear, then one register updated per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (is_write(bus.write_addr)) begin
            regs_r[bus.write_addr] <= bus.data_in;
        end
    end

    // Architectural view of all 32 registers with slot 0 tied to zero.
    always_comb begin
        view_s[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            view_s[i] = regs_r[i];
        end
    end

    // Read port muxes, optionally forwarding the in-flight write.
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
`ifdef REGFILE_BYPASS_EN
        if (bypass_hit(bus.read1_addr, bus.write_addr)) begin
            rd1_s = bus.data_in;
        end else begin
            rd1_s = view_s[bus.read1_addr];
        end
        if (bypass_hit(bus.read2_addr, bus.write_addr)) begin
            rd2_s = bus.data_in;
        end else begin
            rd2_s = view_s[bus.read2_addr];
        end
`else
        rd1_s = view_s[bus.read1_addr];
        rd2_s = view_s[bus.read2_addr];
`endif
    end

    // Debug mirror shows stored contents only, never forwarded data.
    always_comb begin
        dbg_s = view_s[DEBUG_IDX];
    end

    assign bus.data_out1 = rd1_s;
    assign bus.data_out2 = rd2_s;
    assign bus.debug_out = dbg_s;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: vector table plus reset, collision
// and full-sweep sequences; expectations follow REGFILE_BYPASS_EN.
module tb_mips_register_file;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    mips_register_file_if bus ();

    mips_register_file #(.DEBUG_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] din;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] wa, input logic [31:0] din,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.write_addr = wa;
        bus.data_in    = din;
        bus.read1_addr = r1;
        bus.read2_addr = r2;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Expected values reflect state before the edge that follows each vector.
        vecs[0]  = '{5'd0,  32'h0000_0000, 5'd5,  5'd31, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{5'd3,  32'hDEAD_BEEF, 5'd3,  5'd3,
                     BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0};
        vecs[2]  = '{5'd0,  32'hFFFF_FFFF, 5'd3,  5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{5'd0,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0, 32'h0, 32'h0};
        vecs[4]  = '{5'd0,  32'h0000_0000, 5'd31, 5'd0,  32'h0, 32'h0, 32'h0};
        vecs[5]  = '{5'd7,  32'h1111_1111, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
        vecs[6]  = '{5'd7,  32'h2222_2222, 5'd7,  5'd3,
                     BYP ? 32'h2222_2222 : 32'h1111_1111, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{5'd0,  32'h0000_0000, 5'd7,  5'd7,  32'h2222_2222, 32'h2222_2222, 32'h0};
        vecs[8]  = '{5'd1,  32'h0000_0042, 5'd1,  5'd7,
                     BYP ? 32'h0000_0042 : 32'h0, 32'h2222_2222, 32'h0};
        vecs[9]  = '{5'd0,  32'h0000_0000, 5'd1,  5'd1,  32'h0000_0042, 32'h0000_0042, 32'h0000_0042};
        vecs[10] = '{5'd1,  32'hAAAA_5555, 5'd2,  5'd1,
                     32'h0, BYP ? 32'hAAAA_5555 : 32'h0000_0042, 32'h0000_0042};
        vecs[11] = '{5'd0,  32'h0000_0000, 5'd1,  5'd3,  32'hAAAA_5555, 32'hDEAD_BEEF, 32'hAAAA_5555};

        // Reset held from time zero; writes during reset must be dropped.
        rst = 1'b0;
        drive(5'd0, 32'h0, 5'd5, 5'd31);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_out1", bus.data_out1, 32'h0);
        chk("rst_out2", bus.data_out2, 32'h0);
        chk("rst_dbg",  bus.debug_out, 32'h0);
        @(negedge clk);
        drive(5'd4, 32'hCAFE_F00D, 5'd4, 5'd31);
        #2;
        chk("rst_bypass", bus.data_out1, BYP ? 32'hCAFE_F00D : 32'h0);
        chk("rst_out2b",  bus.data_out2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(5'd0, 32'h0, 5'd4, 5'd4);
        #2;
        chk("rst_write_ignored", bus.data_out1, 32'h0);

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            drive(vecs[v].wa, vecs[v].din, vecs[v].r1, vecs[v].r2);
            #2;
            chk($sformatf("vec%0d_out1", v), bus.data_out1, vecs[v].e1);
            chk($sformatf("vec%0d_out2", v), bus.data_out2, vecs[v].e2);
            chk($sformatf("vec%0d_dbg", v),  bus.debug_out, vecs[v].ed);
        end

        // Asynchronous reset pulled low between edges.
        @(negedge clk);
        drive(5'd0, 32'h0, 5'd1, 5'd3);
        #2;
        chk("pre_async_out1", bus.data_out1, 32'hAAAA_5555);
        chk("pre_async_dbg",  bus.debug_out, 32'hAAAA_5555);
        #1;
        rst = 1'b0;
        #1;
        chk("async_out1", bus.data_out1, 32'h0);
        chk("async_out2", bus.data_out2, 32'h0);
        chk("async_dbg",  bus.debug_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(5'd0, 32'h0, 5'd3, 5'd7);
        #2;
        chk("post_async_r3", bus.data_out1, 32'h0);
        chk("post_async_r7", bus.data_out2, 32'h0);

        // Full sweep of registers 1..31.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #2;
        chk("sweep_r0", bus.data_out1, 32'h0);
        chk("sweep_dbg", bus.debug_out, 32'h0101_0101);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(5'd0, 32'h0, 5'(i), 5'(32 - i));
            #2;
            chk($sformatf("sweep_out1_r%0d", i), bus.data_out1, 32'(i) * 32'h0101_0101);
            chk($sformatf("sweep_out2_r%0d", 32 - i), bus.data_out2, 32'(32 - i) * 32'h0101_0101);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
